alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_settle_cnt.sv | 40 ++++
 rtl/alu_seq_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencing controller:
//   - state_e     : controller FSM states
//   - SHIFT_BIT, ARITH_BIT, DIR_BIT : bit positions inside the 5-bit select code
//   - FLAG_NEG, FLAG_CARRY, FLAG_ZERO : bit indices inside out_flags
//   - CNT_W       : width of the settle / shift down-counters
// ----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int SHIFT_BIT = 4;
    localparam int ARITH_BIT = 3;
    localparam int DIR_BIT   = 0;   // 1 = shift left

    localparam int FLAG_NEG   = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_ZERO  = 0;

    // Wide enough for SETTLE-1 (SETTLE <= 15) and a 4-bit shift count.
    localparam int CNT_W = 4;

endpackage : alu_pkg

// File: rtl/alu_settle_cnt.sv
// ----------------------------------------------------------------------------
// alu_settle_cnt
// Loadable down-counter with a zero flag. Load has priority over decrement;
// decrementing stops at zero.
//   clk, rst_n   : clock, synchronous active-low reset (clears count)
//   load_i       : load load_val_i this cycle
//   load_val_i   : value to load
//   dec_i        : decrement by one (ignored when already zero)
//   cnt_o        : current count
//   zero_o       : count == 0
// ----------------------------------------------------------------------------
module alu_settle_cnt
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: reset is sampled inside the clocked block, so it only takes effect on a rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && !zero_o) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule : alu_settle_cnt

// File: rtl/alu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// alu_seq_ctrl
// Sequences a combinational ALU that needs SETTLE cycles after its inputs
// change. Accepts one request at a time, drives the ALU through registered
// alu_* outputs, waits for settling, captures the result, and iterates
// single-bit shifts in_shamt times by feeding alu_y back into alu_a.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : request handshake (in_ready only in IDLE)
//   in_sel, in_a, in_b,
//   in_cin, in_shamt      : request fields
//   alu_sel, alu_a,
//   alu_b, alu_cin        : registered drive to the external ALU
//   alu_y, alu_cout       : external ALU result
//   out_valid / out_ready : result handshake (out_valid only in HOLD)
//   out_y, out_flags      : registered result and {neg, carry, zero}
// ----------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [3:0]       in_shamt,
    output logic [4:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_flags
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_y_q;
    logic [2:0]       out_flags_q;
    logic [4:0]       alu_sel_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             alu_cin_q;

    logic [CNT_W-1:0] settle_cnt, shift_cnt;
    logic             settle_zero, shift_zero;
    logic             accept, zero_shift, shift_last, reload;
    logic             settle_load, settle_dec, shift_dec;
    logic             shift_out_bit;

    function automatic logic [2:0] make_flags(input logic [WIDTH-1:0] y, input logic c);
        logic [2:0] f;
        f             = '0;
        f[FLAG_NEG]   = y[WIDTH-1];
        f[FLAG_CARRY] = c;
        f[FLAG_ZERO]  = (y == '0);
        return f;
    endfunction

    assign accept     = in_valid && in_ready_q;
    assign zero_shift = in_sel[SHIFT_BIT] && (in_shamt == '0);
    // Counter still holds the pre-decrement value in CAPT, so 1 means this is the last pass.
    assign shift_last = (shift_cnt == CNT_W'(1));
    assign reload     = (state_q == ST_CAPT) && alu_sel_q[SHIFT_BIT] && !shift_last;

    assign settle_load = (accept && !zero_shift) || reload;
    assign settle_dec  = (state_q == ST_DRIVE) && (settle_cnt != '0);
    assign shift_dec   = (state_q == ST_CAPT) && alu_sel_q[SHIFT_BIT] && !shift_zero;

    // The bit that falls off the end of the current single-step shift.
    assign shift_out_bit = alu_sel_q[DIR_BIT] ? alu_a_q[WIDTH-1] : alu_a_q[0];

    alu_settle_cnt u_settle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (settle_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (settle_dec),
        .cnt_o      (settle_cnt),
        .zero_o     (settle_zero)
    );

    alu_settle_cnt u_shift_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (in_shamt),
        .dec_i      (shift_dec),
        .cnt_o      (shift_cnt),
        .zero_o     (shift_zero)
    );

    // NOTE: all state here is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_flags_q <= '0;
            alu_sel_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (zero_shift) begin
                            // Nothing to shift: result is the operand, ALU drive untouched.
                            out_y_q     <= in_a;
                            out_flags_q <= make_flags(in_a, 1'b0);
                            out_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else begin
                            alu_sel_q <= in_sel;
                            alu_a_q   <= in_a;
                            alu_b_q   <= in_b;
                            alu_cin_q <= in_cin;
                            state_q   <= ST_DRIVE;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (settle_zero) begin
                        state_q <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (!alu_sel_q[SHIFT_BIT]) begin
                        out_y_q     <= alu_y;
                        out_flags_q <= make_flags(alu_y, alu_cout);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else if (!shift_last) begin
                        alu_a_q <= alu_y;
                        state_q <= ST_DRIVE;
                    end else begin
                        out_y_q     <= alu_y;
                        out_flags_q <= make_flags(alu_y, shift_out_bit);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_flags = out_flags_q;
    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;

endmodule : alu_seq_ctrl
